// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and load/store.
// Data has priority; results are registered and pipe_stall holds until every live requester is served.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [DATA_W-1:0] if_instr,
    output logic              if_ok,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [1:0]        mem_bytes,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ok,
    output logic              pipe_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [1:0]        bus_be,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_FETCH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_bus_req;
    logic                r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic [1:0]          r_bus_be;
    logic [1:0]          r_bytes;
    logic [DATA_W-1:0]   r_if_instr;
    logic [DATA_W-1:0]   r_mem_rdata;
    logic                r_if_ok;
    logic                r_mem_ok;
    logic                r_bus_err;
    logic                r_discard;
    logic [CNT_W-1:0]    r_wait;

    logic                w_dpend;
    logic                w_fpend;
    logic                w_stall;
    logic                w_grant_data;
    logic                w_grant_fetch;
    logic                w_busy;
    logic                w_timeout;
    logic                w_done;
    logic                w_fetch_keep;
    logic [DATA_W-1:0]   w_load_data;

    assign w_dpend = mem_rd | mem_wr;
    assign w_fpend = if_req & ~if_kill;
    assign w_stall = (w_dpend & ~r_mem_ok) | (w_fpend & ~r_if_ok);

    // Reset drops the stall immediately, without waiting for an edge.
    assign pipe_stall = w_stall & ~reset;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_data) begin
                    w_state_nxt = S_DATA;
                end else if (w_grant_fetch) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_DATA, S_FETCH: begin
                if (w_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output/decode logic
    always_comb begin
        w_grant_data  = 1'b0;
        w_grant_fetch = 1'b0;
        w_busy        = (r_state == S_DATA) || (r_state == S_FETCH);
        w_timeout     = 1'b0;
        w_done        = 1'b0;
        w_fetch_keep  = 1'b0;
        w_load_data   = bus_rdata;
        if (r_state == S_IDLE) begin
            w_grant_data  = w_dpend & ~r_mem_ok;
            w_grant_fetch = ~w_grant_data & w_fpend & ~r_if_ok;
        end
        w_timeout    = w_busy & r_bus_req & ~bus_ack & (r_wait == CNT_W'(MAX_WAIT - 1));
        w_done       = (w_busy & bus_ack) | w_timeout;
        w_fetch_keep = (r_state == S_FETCH) & ~r_discard & ~if_kill;
        case (r_bytes)
            2'b01:   w_load_data = DATA_W'(bus_rdata[7:0]);
            2'b10:   w_load_data = {{(DATA_W - 8){bus_rdata[7]}}, bus_rdata[7:0]};
            default: w_load_data = bus_rdata;
        endcase
    end

    // Bus request registers, wait counter and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= 2'b00;
            r_bytes     <= 2'b00;
            r_if_instr  <= '0;
            r_mem_rdata <= '0;
            r_if_ok     <= 1'b0;
            r_mem_ok    <= 1'b0;
            r_bus_err   <= 1'b0;
            r_discard   <= 1'b0;
            r_wait      <= '0;
        end else begin
            r_bus_err <= w_timeout;

            if (w_grant_data) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= mem_wr;
                r_bus_addr  <= mem_addr;
                r_bus_wdata <= mem_wdata;
                r_bytes     <= mem_bytes;
                r_bus_be    <= ((mem_bytes == 2'b01) || (mem_bytes == 2'b10)) ? 2'b01 : 2'b11;
            end else if (w_grant_fetch) begin
                r_bus_req  <= 1'b1;
                r_bus_we   <= 1'b0;
                r_bus_addr <= if_addr;
                r_bus_be   <= 2'b11;
            end else if (w_done) begin
                r_bus_req <= 1'b0;
            end

            if (w_grant_data || w_grant_fetch || w_done) begin
                r_wait <= '0;
            end else if (w_busy && r_bus_req && !bus_ack) begin
                r_wait <= r_wait + CNT_W'(1);
            end

            // A kill during a fetch only marks its result for dropping.
            if (w_done) begin
                r_discard <= 1'b0;
            end else if ((r_state == S_FETCH) && if_kill) begin
                r_discard <= 1'b1;
            end

            if ((r_state == S_DATA) && w_done) begin
                r_mem_ok <= 1'b1;
                if (w_timeout) begin
                    r_mem_rdata <= '0;
                end else if (!r_bus_we) begin
                    r_mem_rdata <= w_load_data;
                end
            end else if (!w_stall) begin
                r_mem_ok <= 1'b0;
            end

            if ((r_state == S_FETCH) && w_done && w_fetch_keep) begin
                r_if_ok    <= 1'b1;
                r_if_instr <= w_timeout ? '0 : bus_rdata;
            end else if (if_kill || !w_stall) begin
                r_if_ok <= 1'b0;
            end
        end
    end

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_be    = r_bus_be;
    assign bus_err   = r_bus_err;
    assign if_instr  = r_if_instr;
    assign if_ok     = r_if_ok;
    assign mem_rdata = r_mem_rdata;
    assign mem_ok    = r_mem_ok;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a configurable-latency bus responder.
// Expected values are hand-computed from the arbiter's documented cycle behaviour.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_kill = 1'b0;
    logic [15:0] if_instr;
    logic        if_ok;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [1:0]  mem_bytes = 2'b00;
    logic [15:0] mem_rdata;
    logic        mem_ok;
    logic        pipe_stall;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [1:0]  bus_be;
    logic [15:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    int          n_chk = 0;
    int          n_err = 0;

    // Bus responder: ack on the ack_dly-th cycle of bus_req (0 = never ack).
    int          ack_dly = 1;
    logic [15:0] rd_val = '0;
    int          req_cycles = 0;
    logic        prev_req = 1'b0;
    int          iss_cnt = 0;
    logic [15:0] log_addr  [0:7];
    logic [15:0] log_wdata [0:7];
    logic        log_we    [0:7];
    logic [1:0]  log_be    [0:7];

    assign bus_rdata = rd_val;
    assign bus_ack   = bus_req && (ack_dly != 0) && (req_cycles == ack_dly - 1);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!bus_req || bus_ack) req_cycles <= 0;
        else                     req_cycles <= req_cycles + 1;
        if (bus_req && !prev_req) begin
            log_addr[iss_cnt & 7]  <= bus_addr;
            log_wdata[iss_cnt & 7] <= bus_wdata;
            log_we[iss_cnt & 7]    <= bus_we;
            log_be[iss_cnt & 7]    <= bus_be;
            iss_cnt                <= iss_cnt + 1;
        end
        prev_req <= bus_req;
    end

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_instr(if_instr), .if_ok(if_ok),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_bytes(mem_bytes),
        .mem_rdata(mem_rdata), .mem_ok(mem_ok), .pipe_stall(pipe_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts stalled cycles from the current one until pipe_stall releases.
    task automatic wait_release(output int n);
        n = 0;
        while (pipe_stall && n < 40) begin
            n++;
            tick();
        end
        if (pipe_stall) chk("stall_bound", 32'(pipe_stall), 32'(0));
    endtask

    task automatic data_access(input string tag, input logic wr, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [1:0] bytes,
                               input int dly, input logic [15:0] rval,
                               input int exp_n, input logic [15:0] exp_rdata,
                               input logic [1:0] exp_be);
        int base;
        int n;
        base      = iss_cnt;
        ack_dly   = dly;
        rd_val    = rval;
        mem_rd    = ~wr;
        mem_wr    = wr;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_bytes = bytes;
        #1;
        wait_release(n);
        chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_n));
        chk({tag, "_mem_ok"}, 32'(mem_ok), 32'(1));
        chk({tag, "_mem_rdata"}, 32'(mem_rdata), 32'(exp_rdata));
        chk({tag, "_issues"}, 32'(iss_cnt - base), 32'(1));
        chk({tag, "_bus_addr"}, 32'(log_addr[base & 7]), 32'(addr));
        chk({tag, "_bus_we"}, 32'(log_we[base & 7]), 32'(wr));
        chk({tag, "_bus_be"}, 32'(log_be[base & 7]), 32'(exp_be));
        if (wr) chk({tag, "_bus_wdata"}, 32'(log_wdata[base & 7]), 32'(wdata));
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        tick();
        chk({tag, "_ok_clear"}, 32'(mem_ok), 32'(0));
    endtask

    initial begin
        int n;
        int base;

        // Reset state
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'(0));
        chk("rst_flags", 32'({if_ok, mem_ok, bus_err, pipe_stall}), 32'(0));
        chk("rst_data", 32'({if_instr, mem_rdata}), 32'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // Loads and stores through the data port
        data_access("ld_word", 1'b0, 16'h0040, 16'h0000, 2'b00, 1, 16'hBEEF, 2, 16'hBEEF, 2'b11);
        data_access("ld_zext", 1'b0, 16'h0042, 16'h0000, 2'b01, 1, 16'h12F0, 2, 16'h00F0, 2'b01);
        data_access("ld_sext", 1'b0, 16'h0043, 16'h0000, 2'b10, 1, 16'h12F0, 2, 16'hFFF0, 2'b01);
        data_access("st_byte", 1'b1, 16'h0044, 16'hAB55, 2'b01, 1, 16'h0000, 2, 16'hFFF0, 2'b01);

        // Contention: data first, then fetch, one access each
        base    = iss_cnt;
        ack_dly = 2;
        rd_val  = 16'h5A5A;
        mem_rd  = 1'b1;
        mem_addr = 16'h0100;
        mem_bytes = 2'b00;
        if_req  = 1'b1;
        if_addr = 16'h0200;
        #1;
        wait_release(n);
        chk("cont_stall_cycles", 32'(n), 32'(6));
        chk("cont_issues", 32'(iss_cnt - base), 32'(2));
        chk("cont_first_addr", 32'(log_addr[base & 7]), 32'(16'h0100));
        chk("cont_second_addr", 32'(log_addr[(base + 1) & 7]), 32'(16'h0200));
        chk("cont_oks", 32'({mem_ok, if_ok}), 32'(2'b11));
        chk("cont_results", 32'({mem_rdata, if_instr}), 32'({16'h5A5A, 16'h5A5A}));
        mem_rd = 1'b0;
        if_req = 1'b0;
        tick();
        chk("cont_ok_clear", 32'({mem_ok, if_ok}), 32'(0));

        // Kill an in-flight fetch, then fetch the redirected address
        ack_dly = 3;
        rd_val  = 16'h1234;
        if_req  = 1'b1;
        if_addr = 16'h0300;
        tick();
        chk("kill_bus_addr", 32'({bus_req, bus_addr}), 32'({1'b1, 16'h0300}));
        if_kill = 1'b1;
        tick();
        if_kill = 1'b0;
        if_addr = 16'h0400;
        tick();
        tick();
        chk("kill_dropped", 32'({bus_req, if_ok, pipe_stall}), 32'(3'b001));
        chk("kill_instr_kept", 32'(if_instr), 32'(16'h5A5A));
        base    = iss_cnt;
        ack_dly = 1;
        rd_val  = 16'h7777;
        wait_release(n);
        chk("refetch_stall_cycles", 32'(n), 32'(2));
        chk("refetch_result", 32'({if_ok, if_instr}), 32'({1'b1, 16'h7777}));
        chk("refetch_addr", 32'(log_addr[base & 7]), 32'(16'h0400));
        if_req = 1'b0;
        tick();
        chk("refetch_ok_clear", 32'(if_ok), 32'(0));

        // Bus timeout on a load
        ack_dly  = 0;
        rd_val   = 16'hDEAD;
        mem_rd   = 1'b1;
        mem_addr = 16'h0500;
        #1;
        wait_release(n);
        chk("to_stall_cycles", 32'(n), 32'(16));
        chk("to_err_ok", 32'({bus_err, mem_ok, bus_req}), 32'(3'b110));
        chk("to_rdata", 32'(mem_rdata), 32'(0));
        mem_rd = 1'b0;
        tick();
        chk("to_err_pulse", 32'({bus_err, mem_ok}), 32'(0));

        // Asynchronous reset in the middle of an access
        mem_rd   = 1'b1;
        mem_addr = 16'h0600;
        tick();
        tick();
        chk("mid_busy", 32'({bus_req, pipe_stall}), 32'(2'b11));
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_drop", 32'({bus_req, mem_ok, if_ok, pipe_stall}), 32'(0));
        #1 reset = 1'b0;
        ack_dly = 1;
        rd_val  = 16'h0ACE;
        base    = iss_cnt;
        #1;
        wait_release(n);
        chk("post_rst_stall", 32'(n), 32'(2));
        chk("post_rst_result", 32'({mem_ok, mem_rdata}), 32'({1'b1, 16'h0ACE}));
        chk("post_rst_addr", 32'(log_addr[base & 7]), 32'(16'h0600));
        mem_rd = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
